pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register between two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_stage_skid_if.sv | 17 +
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_skid.sv | 130 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for CPU pipeline stage registers: default widths per stage pair,
// control-word field offsets and the skid-stage state encoding.
package pipe_pkg;

  localparam int unsigned CtrlWDefault = 82;
  localparam int unsigned DataWDefault = 80;

  // Per stage-pair widths; each boundary carries only what later stages still need
  localparam int unsigned IfIdCtrlW  = 82;
  localparam int unsigned IfIdDataW  = 80;
  localparam int unsigned IdExCtrlW  = 82;
  localparam int unsigned IdExDataW  = 80;
  localparam int unsigned ExMemCtrlW = 64;
  localparam int unsigned ExMemDataW = 64;
  localparam int unsigned MemWbCtrlW = 48;
  localparam int unsigned MemWbDataW = 32;

  // Control-word field offsets (bit positions from LSB)
  localparam int unsigned CtrlEretBit    = 0;
  localparam int unsigned CtrlIntBit     = 1;
  localparam int unsigned CtrlSyscallBit = 2;
  localparam int unsigned CtrlBreakBit   = 3;
  localparam int unsigned CtrlRiBit      = 4;
  localparam int unsigned CtrlAdelBit    = 5;
  localparam int unsigned CtrlRegWeBit   = 6;
  localparam int unsigned CtrlDestLsb    = 7;
  localparam int unsigned CtrlDestW      = 5;
  localparam int unsigned CtrlPcLsb      = 12;
  localparam int unsigned CtrlPcW        = 32;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } stage_st_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/allow handshake bundle carrying a control word and a data word between stages.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault
);

  logic              valid;
  logic              allow;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input allow);
  modport slave  (input valid, input ctrl, input data, output allow);

endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus payload, with load/clear enables and async reset.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned W       = CtrlWDefault + DataWDefault,
  parameter bit          RST_CLR = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic         valid_i,
  input  logic         ld_i,
  input  logic [W-1:0] pay_i,
  output logic         valid_o,
  output logic [W-1:0] pay_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] pay_d, pay_q;

  // Clear wins over write so a flush always empties the slot
  always_comb begin
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (we_i) begin
      valid_d = valid_i;
    end
  end

  assign pay_d = ld_i ? pay_i : pay_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  generate
    if (RST_CLR) begin : g_pay_rst
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pay_q <= '0;
        else         pay_q <= pay_d;
      end
    end else begin : g_pay_norst
      always_ff @(posedge clk) begin
        pay_q <= pay_d;
      end
    end
  endgenerate

  assign valid_o = valid_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/allow handshake and synchronous flush.
// Define PIPE_SKID_EN to add a second (skid) slot so up_allow comes straight from a flop.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W  = CtrlWDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter bit          RST_CLR = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic [1:0] occ
);

  localparam int unsigned PayW = CTRL_W + DATA_W;

  logic [PayW-1:0] up_pay, q_pay, q_pay_in;
  logic            q_valid, q_we, q_vld_d, q_ld;
  logic            up_allow, up_fire;

  assign up_pay   = {up.ctrl, up.data};
  assign up.allow = up_allow;
  assign up_fire  = up.valid & up_allow;

  assign dn.valid = q_valid;
  assign dn.ctrl  = q_pay[PayW-1:DATA_W];
  assign dn.data  = q_pay[DATA_W-1:0];

  pipe_slot #(
    .W       (PayW),
    .RST_CLR (RST_CLR)
  ) u_slot_q (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (flush),
    .we_i    (q_we),
    .valid_i (q_vld_d),
    .ld_i    (q_ld),
    .pay_i   (q_pay_in),
    .valid_o (q_valid),
    .pay_o   (q_pay)
  );

`ifdef PIPE_SKID_EN
  logic            s_valid, s_we, s_vld_d, s_ld;
  logic [PayW-1:0] s_pay;
  logic            dn_fire;
  stage_st_e       st;

  pipe_slot #(
    .W       (PayW),
    .RST_CLR (RST_CLR)
  ) u_slot_s (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (flush),
    .we_i    (s_we),
    .valid_i (s_vld_d),
    .ld_i    (s_ld),
    .pay_i   (up_pay),
    .valid_o (s_valid),
    .pay_o   (s_pay)
  );

  assign up_allow = ~s_valid;
  assign dn_fire  = q_valid & dn.allow;
  assign occ      = {1'b0, q_valid} + {1'b0, s_valid};

  // The slot valid bits are the state register; S is never valid without Q
  always_comb begin
    st       = q_valid ? (s_valid ? StFull : StOne) : StEmpty;
    q_we     = 1'b0;
    q_vld_d  = 1'b0;
    q_ld     = 1'b0;
    q_pay_in = up_pay;
    s_we     = 1'b0;
    s_vld_d  = 1'b0;
    s_ld     = 1'b0;
    unique case (st)
      StEmpty: begin
        if (up_fire) begin
          q_we    = 1'b1;
          q_vld_d = 1'b1;
          q_ld    = 1'b1;
        end
      end
      StOne: begin
        if (up_fire && dn_fire) begin
          q_ld = 1'b1;
        end else if (up_fire) begin
          s_we    = 1'b1;
          s_vld_d = 1'b1;
          s_ld    = 1'b1;
        end else if (dn_fire) begin
          q_we    = 1'b1;
          q_vld_d = 1'b0;
        end
      end
      StFull: begin
        if (dn.allow) begin
          q_ld     = 1'b1;
          q_pay_in = s_pay;
          s_we     = 1'b1;
          s_vld_d  = 1'b0;
        end
      end
      default: ;
    endcase
    // Flush kills valids in the slots; payload flops keep their contents
    if (flush) begin
      q_ld = 1'b0;
      s_ld = 1'b0;
    end
  end
`else
  assign up_allow = ~q_valid | dn.allow;
  assign occ      = {1'b0, q_valid};

  always_comb begin
    q_we     = up_allow;
    q_vld_d  = up.valid;
    q_ld     = up_fire & ~flush;
    q_pay_in = up_pay;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid; follows PIPE_SKID_EN like the RTL.
module tb_pipe_stage_skid;

  localparam int unsigned CW = 82;
  localparam int unsigned DW = 80;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       flush  = 1'b0;
  logic [1:0] occ;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

  pipe_stage_skid #(
    .CTRL_W  (CW),
    .DATA_W  (DW),
    .RST_CLR (1'b1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .up     (up_if),
    .dn     (dn_if),
    .occ    (occ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_up(input logic v, input int unsigned c);
    up_if.valid = v;
    up_if.ctrl  = CW'(c);
    up_if.data  = DW'(c * 3 + 1);
  endtask

  task automatic test_reset();
    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.data  = '0;
    dn_if.allow = 1'b0;
    #1 resetn = 1'b0;
    #1;
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_dn_valid got %b want 0", dn_if.valid); end
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_cmp++; if (up_if.allow !== 1'b1) begin n_err++; $display("FAIL reset_up_allow got %b want 1", up_if.allow); end
    n_cmp++; if (dn_if.ctrl !== '0) begin n_err++; $display("FAIL reset_dn_ctrl got %0h want 0", dn_if.ctrl); end
    n_cmp++; if (dn_if.data !== '0) begin n_err++; $display("FAIL reset_dn_data got %0h want 0", dn_if.data); end
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_streaming();
    dn_if.allow = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive_up(1'b1, i);
      tick();
      n_cmp++; if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, dn_if.valid); end
      n_cmp++; if (dn_if.ctrl !== CW'(i)) begin n_err++; $display("FAIL stream_ctrl[%0d] got %0h want %0h", i, dn_if.ctrl, i); end
      n_cmp++; if (dn_if.data !== DW'(i * 3 + 1)) begin n_err++; $display("FAIL stream_data[%0d] got %0h want %0h", i, dn_if.data, i * 3 + 1); end
    end
    drive_up(1'b0, 0);
    tick();
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid got %b want 0", dn_if.valid); end
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL stream_drain_occ got %0d want 0", occ); end
  endtask

`ifdef PIPE_SKID_EN
  task automatic test_backpressure();
    dn_if.allow = 1'b1;
    drive_up(1'b1, 5);
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'(5)) begin n_err++; $display("FAIL bp_q5 got %0h want 5", dn_if.ctrl); end
    dn_if.allow = 1'b0;
    drive_up(1'b1, 6);
    tick();
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL bp_occ_full got %0d want 2", occ); end
    n_cmp++; if (up_if.allow !== 1'b0) begin n_err++; $display("FAIL bp_up_allow got %b want 0", up_if.allow); end
    drive_up(1'b1, 7);
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'(5)) begin n_err++; $display("FAIL bp_hold got %0h want 5", dn_if.ctrl); end
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL bp_hold_occ got %0d want 2", occ); end
    dn_if.allow = 1'b1;
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'(6)) begin n_err++; $display("FAIL bp_rel6 got %0h want 6", dn_if.ctrl); end
    n_cmp++; if (occ !== 2'd1) begin n_err++; $display("FAIL bp_rel6_occ got %0d want 1", occ); end
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'(7)) begin n_err++; $display("FAIL bp_rel7 got %0h want 7", dn_if.ctrl); end
    drive_up(1'b0, 0);
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL bp_empty_occ got %0d want 0", occ); end
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL bp_empty_valid got %b want 0", dn_if.valid); end
  endtask
`else
  task automatic test_backpressure();
    dn_if.allow = 1'b1;
    drive_up(1'b1, 'hA);
    tick();
    dn_if.allow = 1'b0;
    drive_up(1'b1, 'hB);
    #1;
    n_cmp++; if (up_if.allow !== 1'b0) begin n_err++; $display("FAIL bp_up_allow got %b want 0", up_if.allow); end
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'('hA)) begin n_err++; $display("FAIL bp_hold got %0h want a", dn_if.ctrl); end
    n_cmp++; if (occ !== 2'd1) begin n_err++; $display("FAIL bp_occ got %0d want 1", occ); end
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'('hA)) begin n_err++; $display("FAIL bp_hold2 got %0h want a", dn_if.ctrl); end
    dn_if.allow = 1'b1;
    #1;
    n_cmp++; if (up_if.allow !== 1'b1) begin n_err++; $display("FAIL bp_rel_allow got %b want 1", up_if.allow); end
    tick();
    n_cmp++; if (dn_if.ctrl !== CW'('hB)) begin n_err++; $display("FAIL bp_rel got %0h want b", dn_if.ctrl); end
    drive_up(1'b0, 0);
    tick();
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL bp_empty_valid got %b want 0", dn_if.valid); end
  endtask
`endif

  task automatic test_flush();
    dn_if.allow = 1'b1;
    drive_up(1'b1, 'h11);
    tick();
`ifdef PIPE_SKID_EN
    dn_if.allow = 1'b0;
    drive_up(1'b1, 'h22);
    tick();
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got %0d want 2", occ); end
`else
    dn_if.allow = 1'b1;
`endif
    flush = 1'b1;
    drive_up(1'b1, 'h33);
    tick();
    flush = 1'b0;
    drive_up(1'b0, 0);
    #1;
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", dn_if.valid); end
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occ); end
    n_cmp++; if (dn_if.ctrl !== CW'('h11)) begin n_err++; $display("FAIL flush_payload got %0h want 11", dn_if.ctrl); end
    n_cmp++; if (up_if.allow !== 1'b1) begin n_err++; $display("FAIL flush_up_allow got %b want 1", up_if.allow); end
    tick();
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_lost got %b want 0", dn_if.valid); end
    dn_if.allow = 1'b1;
    drive_up(1'b1, 'h44);
    tick();
    drive_up(1'b0, 0);
    flush = 1'b1;
    #1;
    n_cmp++; if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL flush_dnfire_valid got %b want 1", dn_if.valid); end
    n_cmp++; if (dn_if.ctrl !== CW'('h44)) begin n_err++; $display("FAIL flush_dnfire_ctrl got %0h want 44", dn_if.ctrl); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_once got %b want 0", dn_if.valid); end
    tick();
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_nodup got %b want 0", dn_if.valid); end
  endtask

  task automatic test_reset_midstream();
    dn_if.allow = 1'b1;
    drive_up(1'b1, 'h61);
    tick();
`ifdef PIPE_SKID_EN
    dn_if.allow = 1'b0;
    drive_up(1'b1, 'h62);
    tick();
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL rst_mid_pre_occ got %0d want 2", occ); end
`else
    n_cmp++; if (occ !== 2'd1) begin n_err++; $display("FAIL rst_mid_pre_occ got %0d want 1", occ); end
`endif
    resetn = 1'b0;
    #1;
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", dn_if.valid); end
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL rst_mid_occ got %0d want 0", occ); end
    n_cmp++; if (up_if.allow !== 1'b1) begin n_err++; $display("FAIL rst_mid_up_allow got %b want 1", up_if.allow); end
    n_cmp++; if (dn_if.ctrl !== '0) begin n_err++; $display("FAIL rst_mid_ctrl got %0h want 0", dn_if.ctrl); end
    drive_up(1'b0, 0);
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [CW-1:0] qc[$];
    logic [DW-1:0] qd[$];
    int unsigned   seq = 1;
    logic          exp_allow, uf, df;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      up_if.ctrl  = CW'(seq);
      up_if.data  = DW'($urandom);
      dn_if.allow = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 39) == 0);
`ifdef PIPE_SKID_EN
      exp_allow = (qc.size() < 2);
`else
      exp_allow = (qc.size() == 0) || dn_if.allow;
`endif
      #1;
      n_cmp++; if (occ !== 2'(qc.size())) begin n_err++; $display("FAIL rnd_occ[%0d] got %0d want %0d", cyc, occ, qc.size()); end
      n_cmp++; if (up_if.allow !== exp_allow) begin n_err++; $display("FAIL rnd_up_allow[%0d] got %b want %b", cyc, up_if.allow, exp_allow); end
      n_cmp++; if (dn_if.valid !== (qc.size() != 0)) begin n_err++; $display("FAIL rnd_dn_valid[%0d] got %b want %b", cyc, dn_if.valid, qc.size() != 0); end
      if (qc.size() != 0) begin
        n_cmp++; if (dn_if.ctrl !== qc[0]) begin n_err++; $display("FAIL rnd_ctrl[%0d] got %0h want %0h", cyc, dn_if.ctrl, qc[0]); end
        n_cmp++; if (dn_if.data !== qd[0]) begin n_err++; $display("FAIL rnd_data[%0d] got %0h want %0h", cyc, dn_if.data, qd[0]); end
      end
      df = (qc.size() != 0) && dn_if.allow;
      uf = up_if.valid && exp_allow;
      if (df) begin
        void'(qc.pop_front());
        void'(qd.pop_front());
      end
      if (flush) begin
        qc.delete();
        qd.delete();
      end else if (uf) begin
        qc.push_back(up_if.ctrl);
        qd.push_back(up_if.data);
        seq++;
      end
      tick();
    end
    flush       = 1'b0;
    up_if.valid = 1'b0;
  endtask

  initial begin
    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.data  = '0;
    dn_if.allow = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
